// File: rtl/interlock_unit.sv
// interlock_unit: decode-side hazard detector for the 5-stage RV32 core.
// It detects load-use hazards, MUL/DIV scoreboard hazards and the MUL/DIV
// structural hazard, and it gives a taken IX redirect priority over any stall.
// Optional feature macro: INTERLOCK_PERF_EN builds a 32-bit stall-cycle counter.
// When the macro is not defined, stall_count is tied to 0.
module interlock_unit #(
  parameter int unsigned NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USE_RS1,
  input  logic        ID_USE_RS2,
  input  logic        ID_IS_MD,
  input  logic [4:0]  IX_RD,
  input  logic        IX_IS_LOAD,
  input  logic        IX_MD_START,
  input  logic        IX_BR_TAKEN,
  input  logic        MD_DONE,
  input  logic [4:0]  MD_RD,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idix_bubble,
  output logic        ifid_flush,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  localparam int unsigned CW = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             rs1_hit, rs2_hit;
  logic             load_use, sb_hit, md_struct, stall;

  // Hazard terms, evaluated in the same cycle as their inputs
  always_comb begin
    rs1_hit   = ID_USE_RS1 && (ID_RS1 != 5'd0);
    rs2_hit   = ID_USE_RS2 && (ID_RS2 != 5'd0);
    load_use  = IX_IS_LOAD && (IX_RD != 5'd0) &&
                ((rs1_hit && (ID_RS1 == IX_RD)) || (rs2_hit && (ID_RS2 == IX_RD)));
    sb_hit    = (rs1_hit && pend_q[ID_RS1]) || (rs2_hit && pend_q[ID_RS2]);
    md_struct = ID_IS_MD && md_busy;
    stall     = load_use || sb_hit || md_struct;
  end

  // Pipeline control; a taken redirect flushes instead of stalling
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idix_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (IX_BR_TAKEN) begin
      ifid_flush  = 1'b1;
      idix_bubble = 1'b1;
    end else if (stall) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idix_bubble = 1'b1;
    end
  end

  // Scoreboard next value: the clear is applied first so that a set on the same index wins; x0 is never pending
  always_comb begin
    pend_d = pend_q;
    if (MD_DONE) pend_d[MD_RD] = 1'b0;
    if (IX_MD_START && (IX_RD != 5'd0)) pend_d[IX_RD] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // MUL/DIV FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  // MUL/DIV FSM next state; a start issued while BUSY leaves the FSM in BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (IX_MD_START) state_d = MD_BUSY;
      MD_BUSY: if (MD_DONE && !IX_MD_START) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);

`ifdef INTERLOCK_PERF_EN
  logic [CW-1:0] stall_cnt_q;

  // Count the cycles that are real stalls; redirect cycles are not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      stall_cnt_q <= '0;
    else if (stall && !IX_BR_TAKEN)  stall_cnt_q <= stall_cnt_q + CW'(1);
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: doc/interlock_unit.md
# interlock_unit

Pipeline interlock controller for the 5-stage RV32 core, working opposite the forwarding path. Forwarding resolves RAW hazards whose producer result already exists. This block detects the hazards forwarding cannot resolve, and stalls or flushes the front end until the value exists or the wrong path is gone. It sits beside the decode stage and drives the PC, IF/ID and ID/IX pipeline-register enables. It also tracks a busy state for the multi-cycle MUL/DIV unit.

## Interface
Parameters:
- NREGS, 32, architectural register count; scoreboard width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- ID_RS1, ID_RS2  in  5 each  decode-stage source registers.
- ID_USE_RS1, ID_USE_RS2  in  1 each  decode instruction actually reads that source.
- ID_IS_MD  in  1  decode instruction is MUL/DIV.
- IX_RD  in  5  execute-stage destination register.
- IX_IS_LOAD  in  1  execute-stage instruction is a load.
- IX_MD_START  in  1  MUL/DIV issued from IX this cycle.
- IX_BR_TAKEN  in  1  branch or jump redirect resolved in IX this cycle.
- MD_DONE  in  1  MUL/DIV result written back this cycle.
- MD_RD  in  5  destination of the completing MUL/DIV.
- pc_hold  out  1  PC register keeps its value.
- ifid_hold  out  1  IF/ID register keeps its value.
- idix_bubble  out  1  a NOP is loaded into ID/IX.
- ifid_flush  out  1  IF/ID is cleared to a NOP.
- md_busy  out  1  MUL/DIV FSM is in BUSY.
- stall_count  out  32  stall-cycle counter; present only under the configuration macro.

## Operation
Hazard terms (combinational):
- rs1_hit: ID_USE_RS1 and ID_RS1 != 0. rs2_hit is defined the same way for RS2.
- load_use: IX_IS_LOAD and IX_RD != 0, and (rs1_hit with ID_RS1 == IX_RD, or rs2_hit with ID_RS2 == IX_RD).
- sb_hit: rs1_hit and pend[ID_RS1], or rs2_hit and pend[ID_RS2].
- md_struct: ID_IS_MD and md_busy.
- stall = load_use or sb_hit or md_struct.

Outputs:
- Normal stall: pc_hold = ifid_hold = idix_bubble = 1.
- IX_BR_TAKEN overrides stall: ifid_flush = 1, idix_bubble = 1, pc_hold = ifid_hold = 0.

Scoreboard pend[NREGS-1:0], one bit per register, updated at the clock edge:
- Clear: MD_DONE clears pend[MD_RD].
- Set: IX_MD_START with IX_RD != 0 sets pend[IX_RD].
- Both on the same index in one cycle: set wins.
- pend[0] is constantly 0.

MUL/DIV FSM:
- States: IDLE and BUSY.
- IDLE to BUSY on IX_MD_START.
- BUSY to IDLE on MD_DONE without IX_MD_START.
- MD_DONE and IX_MD_START together keep the FSM in BUSY.
- md_busy = (state == BUSY).
- IX_MD_START while BUSY and without MD_DONE is a protocol error. The FSM stays in BUSY and the scoreboard still sets the bit.

## Timing
- Reset: pend = 0, FSM = IDLE, stall_count = 0. All outputs read 0 while rst_n is low and after release, until inputs assert.
- Hazard outputs are combinational in the same cycle as their inputs. There are no registered outputs except md_busy and stall_count.
- Load-use costs exactly 1 stall cycle: the next cycle the load has moved to IM and is forwarded.
- Scoreboard hit: the stall lasts from the cycle after IX_MD_START through the MD_DONE cycle. The stall drops the cycle after MD_DONE, when the bit reads 0.
- A scoreboard set or clear is visible to decode 1 cycle after the triggering edge.
- Reset asserted mid-operation, including mid-BUSY, clears all state immediately. An outstanding MD_DONE after reset is ignored because the bit is already 0.

## Configuration
- INTERLOCK_PERF_EN defined:
  - stall_count increments by 1 each cycle that stall is 1 and IX_BR_TAKEN is 0.
  - It wraps from 0xFFFFFFFF to 0.
  - It resets to 0.
- Undefined: stall_count is driven constant 0, and no counter flops are built.

## Test plan
- Load-use: IX_IS_LOAD=1, IX_RD=5, ID_RS1=5, ID_USE_RS1=1 -> pc_hold, ifid_hold and idix_bubble are 1 for 1 cycle. With IX_RD=0 the same stimulus gives no stall.
- MUL/DIV scoreboard: IX_MD_START with IX_RD=7, then ID_RS2=7 with ID_USE_RS2=1; MD_DONE with MD_RD=7 after 4 cycles -> stall held 4 cycles, released the cycle after MD_DONE; md_busy 1 over the same window.
- Structural: ID_IS_MD=1 while BUSY -> stall until MD_DONE. MD_DONE plus IX_MD_START in the same cycle on rd=9 -> md_busy stays 1 and pend[9] stays 1.
- Flush priority: load_use and IX_BR_TAKEN both true -> ifid_flush=1, idix_bubble=1, pc_hold=0, and stall_count does not increment.
- Reset mid-BUSY: rst_n low for 1 cycle while pend[3]=1 -> md_busy=0, pend cleared, ID_RS1=3 does not stall.
- Perf counter (INTERLOCK_PERF_EN): preload via 0xFFFFFFFF stall cycles, or force the counter to that value -> the next stall cycle gives 0. Without the macro, stall_count stays at 0 throughout.
